mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between two requesters: the fetch unit (instruction reads) and the load/store path (data reads/writes).
- Sits between the control/fetch logic and the memory. Replaces the direct fetch_done / mem_rd_done / mem_wr_done wiring with one request/done handshake per requester.
- Sequences each multi-cycle memory access with a small state machine.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified memory port: fetch reads vs load/store.
// Optional MEM_ARB_ROUND_ROBIN_EN switches contention from data-first to alternating grants.
module mem_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_done,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [1:0]        data_be,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_done,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic       GRANT_FETCH = 1'b0;
    localparam logic       GRANT_DATA  = 1'b1;
    localparam logic [2:0] CNT_INIT    = 3'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q;
    logic                grant_q;
    logic [2:0]          cnt_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [1:0]          mem_be_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                fetch_done_q;
    logic                data_done_q;
    logic [DATA_W-1:0]   fetch_rdata_q;
    logic [DATA_W-1:0]   data_rdata_q;
    logic                busy_q;

    logic                grant_d;
    logic [1:0]          be_d;

    // A zero byte-enable mask from the load/store path means a full word.
    assign be_d = (data_be == 2'b00) ? 2'b11 : data_be;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    // Under contention the requester that did not win last time gets the port.
    assign grant_d = (data_req && (!fetch_req || (last_grant_q == GRANT_FETCH)))
                     ? GRANT_DATA : GRANT_FETCH;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_FETCH;
        end else if ((state_q == IDLE) && (fetch_req || data_req)) begin
            last_grant_q <= grant_d;
        end
    end
`else
    assign grant_d = data_req ? GRANT_DATA : GRANT_FETCH;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= GRANT_FETCH;
            cnt_q         <= 3'd0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= 2'b00;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            fetch_done_q  <= 1'b0;
            data_done_q   <= 1'b0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
            busy_q        <= 1'b0;
        end else begin
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fetch_req || data_req) begin
                        grant_q  <= grant_d;
                        cnt_q    <= CNT_INIT;
                        mem_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ACCESS;
                        if (grant_d == GRANT_DATA) begin
                            mem_we_q    <= data_we;
                            mem_be_q    <= be_d;
                            mem_addr_q  <= data_addr;
                            mem_wdata_q <= data_wdata;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_be_q    <= 2'b11;
                            mem_addr_q  <= fetch_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == 3'd0) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= DONE;
                        if (grant_q == GRANT_DATA) begin
                            data_done_q <= 1'b1;
                            // Stores leave the last load result visible.
                            if (!mem_we_q) begin
                                data_rdata_q <= mem_rdata;
                            end
                        end else begin
                            fetch_done_q  <= 1'b1;
                            fetch_rdata_q <= mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_be      = mem_be_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign fetch_done  = fetch_done_q;
    assign data_done   = data_done_q;
    assign fetch_rdata = fetch_rdata_q;
    assign data_rdata  = data_rdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: an emulated memory plus a transaction-level
// reference that predicts grant order, port activity, done timing and returned data.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_done;
    logic [15:0] fetch_rdata;
    logic        data_req;
    logic        data_we;
    logic [1:0]  data_be;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic        data_done;
    logic [15:0] data_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(
        .ADDR_W(16),
        .DATA_W(16),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_done(fetch_done),
        .fetch_rdata(fetch_rdata),
        .data_req(data_req),
        .data_we(data_we),
        .data_be(data_be),
        .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_done(data_done),
        .data_rdata(data_rdata),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_be(mem_be),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] env_mem [256];
    logic [15:0] ref_mem [256];
    logic [15:0] exp_frd;
    logic [15:0] exp_drd;
    bit          last_grant;   // 1 = data granted most recently
    int          en_run = 0;

    // Memory emulator: data only valid on the LAT-th consecutive enabled cycle,
    // writes commit on that cycle; every other cycle returns noise.
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            en_run = en_run + 1;
            if (en_run == LAT) begin
                if (mem_we === 1'b1) begin
                    if (mem_be[0]) env_mem[mem_addr[8:1]][7:0]  = mem_wdata[7:0];
                    if (mem_be[1]) env_mem[mem_addr[8:1]][15:8] = mem_wdata[15:8];
                end
                mem_rdata = env_mem[mem_addr[8:1]];
            end else begin
                mem_rdata = 16'($urandom);
            end
        end else begin
            en_run    = 0;
            mem_rdata = 16'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] eff_be(input logic [1:0] be);
        return (be == 2'b00) ? 2'b11 : be;
    endfunction

    // One transaction: requests raised together in an IDLE cycle (cycle 0).
    // Each grant occupies LAT+2 cycles: LAT access cycles, one done cycle, one idle cycle.
    task automatic txn(input bit f, input bit d, input bit we, input logic [1:0] be,
                       input logic [15:0] fa, input logic [15:0] da, input logic [15:0] wd);
        bit          order [2];
        int          nslots;
        int          k;
        int          pos;
        bit          is_d;
        logic [15:0] w;
        if (f && d) begin
            order[0] = RR ? !last_grant : 1'b1;
            order[1] = !order[0];
            nslots   = 2;
        end else begin
            order[0] = d;
            order[1] = 1'b0;
            nslots   = 1;
        end
        fetch_req  = f;
        fetch_addr = fa;
        data_req   = d;
        data_we    = we;
        data_be    = be;
        data_addr  = da;
        data_wdata = wd;
        $display("[TB] txn f=%0b d=%0b we=%0b be=%0b fa=%h da=%h wd=%h first=%s",
                 f, d, we, be, fa, da, wd, order[0] ? "data" : "fetch");
        for (int c = 1; c <= nslots * (LAT + 2) - 1; c++) begin
            k    = (c - 1) / (LAT + 2);
            pos  = (c - 1) % (LAT + 2) + 1;
            is_d = order[k];
            tick();
            if (pos == 1) last_grant = is_d;
            check("mem_en", mem_en, (pos <= LAT));
            check("busy", busy, (pos <= LAT + 1));
            check("fetch_done", fetch_done, (pos == LAT + 1) && !is_d);
            check("data_done", data_done, (pos == LAT + 1) && is_d);
            if (pos <= LAT) begin
                check("mem_addr", mem_addr, is_d ? da : fa);
                check("mem_we", mem_we, is_d ? we : 1'b0);
                check("mem_be", mem_be, is_d ? eff_be(be) : 2'b11);
                if (is_d && we) check("mem_wdata", mem_wdata, wd);
                if (pos == 1) begin
                    if (is_d) begin
                        data_addr  = 16'($urandom);
                        data_wdata = 16'($urandom);
                    end else begin
                        fetch_addr = 16'($urandom);
                    end
                end
            end else if (pos == LAT + 1) begin
                if (is_d) begin
                    if (we) begin
                        w = ref_mem[da[8:1]];
                        if (eff_be(be) & 2'b01) w[7:0]  = wd[7:0];
                        if (eff_be(be) & 2'b10) w[15:8] = wd[15:8];
                        ref_mem[da[8:1]] = w;
                    end else begin
                        exp_drd = ref_mem[da[8:1]];
                    end
                    data_req = 1'b0;
                end else begin
                    exp_frd   = ref_mem[fa[8:1]];
                    fetch_req = 1'b0;
                end
            end
            check("fetch_rdata", fetch_rdata, exp_frd);
            check("data_rdata", data_rdata, exp_drd);
        end
        tick();
        check("idle_busy", busy, 1'b0);
        check("idle_mem_en", mem_en, 1'b0);
        check("idle_dones", {fetch_done, data_done}, 2'b00);
    endtask

    initial begin
        bit          rf;
        bit          rd;
        logic [15:0] tmp;
        reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = 16'h0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = 2'b00;
        data_addr  = 16'h0;
        data_wdata = 16'h0;
        exp_frd    = 16'h0;
        exp_drd    = 16'h0;
        last_grant = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tmp        = 16'($urandom);
            env_mem[i] = tmp;
            ref_mem[i] = tmp;
        end
        env_mem[8] = 16'hA5C3;
        ref_mem[8] = 16'hA5C3;
        tick();
        tick();
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_be", mem_be, 2'b00);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_dones", {fetch_done, data_done}, 2'b00);
        check("rst_rdata", {fetch_rdata, data_rdata}, 32'h0);
        reset = 1'b0;

        txn(1'b1, 1'b0, 1'b0, 2'b11, 16'h0010, 16'h0000, 16'h0000);
        check("single_fetch_rdata", fetch_rdata, 16'hA5C3);
        txn(1'b0, 1'b1, 1'b1, 2'b01, 16'h0000, 16'h0203, 16'h00FF);
        txn(1'b1, 1'b1, 1'b0, 2'b11, 16'h0100, 16'h0180, 16'h0000);
        txn(1'b1, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0010, 16'h0000);
        txn(1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0203, 16'h0000);

        // Reset during the second access cycle of a load.
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_be   = 2'b11;
        data_addr = 16'h0040;
        tick();
        check("mid_rst_en_c1", mem_en, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_mem_en", mem_en, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", data_done, 1'b0);
        check("mid_rst_rdata", data_rdata, 16'h0);
        reset      = 1'b0;
        data_req   = 1'b0;
        exp_frd    = 16'h0;
        exp_drd    = 16'h0;
        last_grant = 1'b0;
        tick();
        check("post_rst_done", data_done, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        txn(1'b0, 1'b1, 1'b0, 2'b11, 16'h0000, 16'h0040, 16'h0000);

        for (int i = 0; i < 40; i++) begin
            rf = 1'($urandom_range(0, 1));
            rd = rf ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(rf, rd, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                16'($urandom_range(0, 511)), 16'($urandom_range(0, 511)), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
